// File: rtl/dcache_responder_pkg.sv
// Shared bus layout and FSM encoding for the data-cache responder.
package dcache_responder_pkg;

   // Request bus: valid, op, addr, uncached, awstrb, wdata, cacop_en, cacop_code, cacop_addr
   localparam int DCACHE_WD        = 106;
   localparam int WD_VALID         = 105;
   localparam int WD_OP            = 104;
   localparam int WD_ADDR_HI       = 103;
   localparam int WD_ADDR_LO       = 72;
   localparam int WD_UNCACHED      = 71;
   localparam int WD_STRB_HI       = 70;
   localparam int WD_STRB_LO       = 67;
   localparam int WD_WDATA_HI      = 66;
   localparam int WD_WDATA_LO      = 35;
   localparam int WD_CACOP_EN      = 34;
   localparam int WD_CACOP_CODE_HI = 33;
   localparam int WD_CACOP_ADDR_HI = 31;

   // Response bus: ready, rvalid, rdata
   localparam int DCACHE_RD   = 34;
   localparam int RD_READY    = 33;
   localparam int RD_RVALID   = 32;
   localparam int RD_RDATA_HI = 31;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed 32-bit memory with per-byte write enables and asynchronous read.
// Contents are deliberately not reset so data survives a responder reset.
module dmem_ram #(
   parameter int WORDS = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [WORDS];

   // Byte-lane writes on the clock edge; unselected lanes keep their value.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dcache_responder.sv
// Data-cache request responder: accepts one request at a time, performs writes
// immediately and returns read data after a fixed latency of LAT cycles.
// Handshake: a request is taken in a cycle where valid=1 and ready=1; the
// initiator holds valid until then, and ready is only offered in IDLE.
module dcache_responder
   import dcache_responder_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int LAT       = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DCACHE_WD-1:0] dcache_wdata_bus,
   output logic [DCACHE_RD-1:0] dcache_rdata_bus,
   input  logic                 stall,
   output logic [1:0]           state_dbg
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam logic [2:0] LAT_M1 = 3'((LAT > 0) ? (LAT - 1) : 0);

   logic          req_valid, req_op, req_cacop;
   logic [31:0]   req_addr, req_wdata;
   logic [3:0]    req_strb;
   logic          ready, accept, cmd_fire, wr_fire, rd_fire;
   logic          rvalid;
   logic [31:0]   rdata, ram_rdata;
   logic [3:0]    ram_we;
   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [31:0]   cap_q, cap_d;
   logic          unused_bus_bits;

   assign req_valid = dcache_wdata_bus[WD_VALID];
   assign req_op    = dcache_wdata_bus[WD_OP];
   assign req_addr  = dcache_wdata_bus[WD_ADDR_HI:WD_ADDR_LO];
   assign req_strb  = dcache_wdata_bus[WD_STRB_HI:WD_STRB_LO];
   assign req_wdata = dcache_wdata_bus[WD_WDATA_HI:WD_WDATA_LO];
   assign req_cacop = dcache_wdata_bus[WD_CACOP_EN];

   // Uncached hint, cache-op code/address and out-of-range address bits have no effect.
   assign unused_bus_bits = ^{dcache_wdata_bus[WD_UNCACHED],
                              dcache_wdata_bus[WD_CACOP_CODE_HI:0],
                              req_addr[31:AW+2], req_addr[1:0]};

   assign ready    = (state_q == ST_IDLE) && !stall && !reset;
   assign accept   = req_valid && ready;
   assign cmd_fire = accept && !req_cacop;   // cache ops are accepted but do nothing
   assign wr_fire  = cmd_fire && req_op;
   assign rd_fire  = cmd_fire && !req_op;
   assign ram_we   = wr_fire ? req_strb : 4'b0000;

   dmem_ram #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (req_addr[AW+1:2]),
      .wdata (req_wdata),
      .rdata (ram_rdata)
   );

   // Next-state, latency counter and read-capture logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_fire && (LAT != 0)) begin
               cap_d = ram_rdata;
               if (LAT == 1) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 3'd1) begin
               state_d = ST_RESP;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset drops any pending read but leaves memory intact.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
         cap_q   <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
      end
   end

   // Response: zero-latency reads bypass the FSM; otherwise RESP presents captured data.
   always_comb begin
      rvalid = 1'b0;
      rdata  = 32'h0;
      if (LAT == 0) begin
         rvalid = rd_fire;
         if (rd_fire) rdata = ram_rdata;
      end else begin
         rvalid = (state_q == ST_RESP) && !reset;
         if (rvalid) rdata = cap_q;
      end
   end

   assign dcache_rdata_bus = {ready, rvalid, rdata};
   assign state_dbg        = state_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: a LAT=2 instance checked through an expected-data
// queue with due cycles, plus a LAT=0 instance checked in-line.
module tb_dcache_responder;
   import dcache_responder_pkg::*;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         stall2 = 1'b0, stall0 = 1'b0;
   logic [105:0] bus2 = '0, bus0 = '0;
   logic [33:0]  rbus2, rbus0;
   logic [1:0]   st2, st0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   logic [31:0] exp_q[$];
   int          due_q[$];

   wire        ready2  = rbus2[33];
   wire        rvalid2 = rbus2[32];
   wire [31:0] rdata2  = rbus2[31:0];
   wire        ready0  = rbus0[33];
   wire        rvalid0 = rbus0[32];
   wire [31:0] rdata0  = rbus0[31:0];

   dcache_responder #(.MEM_WORDS(1024), .LAT(2)) dut2 (
      .clk(clk), .reset(reset), .dcache_wdata_bus(bus2),
      .dcache_rdata_bus(rbus2), .stall(stall2), .state_dbg(st2));

   dcache_responder #(.MEM_WORDS(1024), .LAT(0)) dut0 (
      .clk(clk), .reset(reset), .dcache_wdata_bus(bus0),
      .dcache_rdata_bus(rbus0), .stall(stall0), .state_dbg(st0));

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Request bus with random noise in the fields that must be ignored.
   function automatic logic [105:0] mk(input logic op, input logic [31:0] addr,
                                       input logic [3:0] strb, input logic [31:0] wd,
                                       input logic cacop);
      logic        unc;
      logic [1:0]  code;
      logic [31:0] caddr;
      unc   = 1'($urandom_range(0, 1));
      code  = 2'($urandom_range(0, 3));
      caddr = $urandom();
      return {1'b1, op, addr, unc, strb, wd, cacop, code, caddr};
   endfunction

   // Scoreboard for the LAT=2 instance: every rvalid must match the queue head on its due cycle.
   always @(negedge clk) begin
      if (rvalid2) begin
         if (exp_q.size() == 0) begin
            check("spurious_rvalid", 32'(rvalid2), 32'd0);
         end else begin
            check("rdata", rdata2, exp_q.pop_front());
            check("rvalid_cycle", 32'(cyc), 32'(due_q.pop_front()));
         end
      end else begin
         check("rdata_idle_zero", rdata2, 32'h0);
         if (due_q.size() > 0 && cyc > due_q[0]) begin
            check("rvalid_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one request to the LAT=2 instance and wait (bounded) for acceptance.
   task automatic req2(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic cacop, input logic [31:0] exp_rd,
                       input logic stall_after, output int waited);
      logic got;
      bit   is_read;
      is_read = !op && !cacop;
      bus2 = mk(op, addr, strb, wd, cacop);
      waited = 0;
      got = 1'b0;
      while (!got && waited < 32) begin
         @(negedge clk);
         if (ready2) got = 1'b1;
         else begin
            waited++;
            @(posedge clk); #1;
         end
      end
      if (!got) begin
         check("req_timeout", 32'd0, 32'd1);
         bus2 = '0;
         return;
      end
      if (is_read) begin
         exp_q.push_back(exp_rd);
         due_q.push_back(cyc + 2);
      end else begin
         check("wr_rvalid", 32'(rvalid2), 32'd0);
      end
      @(posedge clk); #1;
      bus2 = '0;
      if (stall_after) stall2 = 1'b1;
      @(negedge clk);
      if (is_read) begin
         check("busy_ready", 32'(ready2), 32'd0);
         check("busy_state", 32'(st2), 32'(ST_WAIT));
      end else begin
         check("wr_state", 32'(st2), 32'(ST_IDLE));
      end
      @(posedge clk); #1;
   endtask

   // Drive one request to the LAT=0 instance; response is checked in the accept cycle.
   task automatic req0(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd, input logic cacop, input logic exp_rv,
                       input logic [31:0] exp_rd);
      bus0 = mk(op, addr, strb, wd, cacop);
      @(negedge clk);
      check("l0_ready", 32'(ready0), 32'd1);
      check("l0_rvalid", 32'(rvalid0), 32'(exp_rv));
      check("l0_rdata", rdata0, exp_rv ? exp_rd : 32'h0);
      @(posedge clk); #1;
      bus0 = '0;
      @(negedge clk);
      check("l0_state", 32'(st0), 32'(ST_IDLE));
      check("l0_rvalid_after", 32'(rvalid0), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int w;
      logic [31:0] a, d;

      // Reset behaviour
      repeat (3) begin
         @(negedge clk);
         check("rst_ready2", 32'(ready2), 32'd0);
         check("rst_rvalid2", 32'(rvalid2), 32'd0);
         check("rst_ready0", 32'(ready0), 32'd0);
         check("rst_state2", 32'(st2), 32'(ST_IDLE));
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready2", 32'(ready2), 32'd1);
      check("post_rst_ready0", 32'(ready0), 32'd1);
      @(posedge clk); #1;

      // Full write then read
      req2(1'b1, 32'h100, 4'hF, 32'h12345678, 1'b0, 32'h0, 1'b0, w);
      req2(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h12345678, 1'b0, w);
      idle(3);

      // Single-lane write through an unaligned address
      req2(1'b1, 32'h101, 4'b0010, 32'h0000AB00, 1'b0, 32'h0, 1'b0, w);
      req2(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h1234AB78, 1'b0, w);
      idle(3);

      // Back-pressure with a held read, then stall raised while the read is pending
      stall2 = 1'b1;
      bus2 = mk(1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
      repeat (3) begin
         @(negedge clk);
         check("stall_ready", 32'(ready2), 32'd0);
         @(posedge clk); #1;
      end
      stall2 = 1'b0;
      req2(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h1234AB78, 1'b1, w);
      check("stall_accept_wait", 32'(w), 32'd0);
      idle(3);
      stall2 = 1'b0;
      idle(1);

      // Reset while a read is in WAIT: the read must be dropped
      bus2 = mk(1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("pre_rst_ready", 32'(ready2), 32'd1);
      @(posedge clk); #1;
      bus2 = '0;
      reset = 1'b1;
      @(negedge clk);
      check("rst_wait_rvalid", 32'(rvalid2), 32'd0);
      check("rst_wait_ready", 32'(ready2), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rel_ready", 32'(ready2), 32'd1);
      check("rel_state", 32'(st2), 32'(ST_IDLE));
      @(posedge clk); #1;
      idle(3);
      req2(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h1234AB78, 1'b0, w);
      req2(1'b0, 32'h1100, 4'h0, 32'h0, 1'b0, 32'h1234AB78, 1'b0, w);

      // Cache op is a no-op even with op=write
      req2(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, w);
      req2(1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0, w);
      req2(1'b0, 32'h100, 4'h0, 32'h0, 1'b0, 32'h1234AB78, 1'b0, w);

      // Random words away from 0x100, with random aliasing bits above the index
      for (int i = 0; i < 6; i++) begin
         a = {20'($urandom_range(0, 32'hFFFFF)), 10'($urandom_range(32'h80, 32'h3FF)), 2'b00};
         d = $urandom();
         req2(1'b1, a, 4'hF, d, 1'b0, 32'h0, 1'b0, w);
         req2(1'b0, a ^ 32'h0010_0000, 4'h0, 32'h0, 1'b0, d, 1'b0, w);
      end

      // Zero-latency instance
      req0(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
      req0(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
      req0(1'b1, 32'h40, 4'hF, 32'h0, 1'b1, 1'b0, 32'h0);
      req0(1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      req0(1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
      req0(1'b1, 32'h43, 4'b1000, 32'h11000000, 1'b0, 1'b0, 32'h0);
      req0(1'b0, 32'h1040, 4'h0, 32'h0, 1'b0, 1'b1, 32'h11FEF00D);

      idle(6);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 Parameter MEM_WORDS, 1024, SHALL set the memory depth in 32-bit words; it SHALL be a power of two.
REQ-002 Parameter LAT, 2, SHALL set the read latency in cycles from accept to rvalid; legal range is 0..7.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 dcache_wdata_bus  input  `EXM_DCACHE_WD (106)  request bus, MSB first: valid, op (0=read, 1=write), addr[31:0], uncached, awstrb[3:0], wdata[31:0], cacop_en, cacop_code[1:0], cacop_addr[31:0].
REQ-006 dcache_rdata_bus  output  `EXM_DCACHE_RD (34)  response bus, MSB first: ready, rvalid, rdata[31:0].
REQ-007 stall  input  1  bench-driven back-pressure; when 1, ready SHALL be 0.

Function
REQ-008 The block SHALL have three states: IDLE, WAIT and RESP.
REQ-009 ready SHALL be 1 only in IDLE with stall=0 and reset=0.
REQ-010 A request SHALL be accepted in any cycle where valid=1 and ready=1; no other cycle accepts a request.
REQ-011 The initiator holds valid until accepted; a valid that is not accepted SHALL cause no state or memory change.
REQ-012 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; upper address bits SHALL be ignored (aliasing); addr[1:0] SHALL be ignored.
REQ-013 An accepted write SHALL update byte lane i (wdata[8i+7:8i]) of the indexed word at that posedge where awstrb[i]=1, and SHALL leave other lanes unchanged.
REQ-014 A write SHALL complete on accept: rvalid SHALL stay 0 and the state SHALL remain IDLE.
REQ-015 An accepted read SHALL capture the indexed word as it stands in the accept cycle; any write accepted earlier SHALL be visible.
REQ-016 With LAT=0, rvalid SHALL be 1 combinationally in the accept cycle, with rdata equal to the word, and the state SHALL stay IDLE.
REQ-017 With LAT=1, a read accept SHALL move the state IDLE->RESP.
REQ-018 With LAT>=2, a read accept SHALL move the state IDLE->WAIT with a down-counter loaded with LAT-1; WAIT SHALL move to RESP when the counter reaches 1.
REQ-019 RESP SHALL last exactly one cycle with rvalid=1 and rdata equal to the captured word, then return to IDLE.
REQ-020 rvalid SHALL be asserted exactly LAT cycles after the accept cycle, exactly once per read.
REQ-021 rdata SHALL be 32'h0 whenever rvalid=0.
REQ-022 Requests SHALL NOT be accepted in WAIT or RESP; one outstanding read at most.
REQ-023 An accepted request with cacop_en=1 SHALL be a no-op: ready=1 in that cycle, no memory change, no rvalid, state stays IDLE; op SHALL be ignored.
REQ-024 The uncached bit and cacop_code/cacop_addr SHALL be ignored.
REQ-025 If stall rises while in WAIT or RESP, the pending response SHALL still be delivered on time.

Reset
REQ-026 While reset=1, ready=0, rvalid=0 and rdata=0.
REQ-027 Reset SHALL force the state to IDLE and clear the counter and captured data.
REQ-028 A read pending at reset SHALL be dropped with no rvalid.
REQ-029 Memory contents SHALL be preserved across reset.
REQ-030 In the first cycle after reset deasserts, ready SHALL be 1 if stall=0.

Structure
REQ-031 `EXM_DCACHE_WD, `EXM_DCACHE_RD, the bus field offsets and the state encodings SHALL live in define.vh.
REQ-032 Storage SHALL be a sub-module dmem_ram: MEM_WORDS x 32, four byte write enables, asynchronous read.
REQ-033 dcache_responder SHALL contain the FSM, the latency counter and the bus pack/unpack logic.

Verification
REQ-034 LAT=2: write addr 0x100, wdata 0x12345678, awstrb 1111 -> ready=1 in that cycle, rvalid=0. Then read 0x100 -> ready=1 at accept; rvalid=1 and rdata=0x12345678 exactly 2 cycles later; rvalid=0 in all other cycles.
REQ-035 Write addr 0x101, awstrb 0010, wdata 0x0000AB00 -> a read of 0x100 SHALL return 0x1234AB78.
REQ-036 stall=1 for 3 cycles with a read held valid -> ready=0 for 3 cycles; accept on the 4th cycle; rvalid 2 cycles later.
REQ-037 Reset pulsed in WAIT -> no rvalid; ready=1 in the first cycle after release; read 0x100 returns 0x1234AB78. Read 0x1100 (MEM_WORDS=1024) returns the same value through aliasing.
REQ-038 LAT=0 instance: a read of a written word -> ready=1 and rvalid=1 in the same cycle with correct rdata. A cacop_en=1 request -> ready=1, no rvalid, memory unchanged.
